// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file.
package regfile_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef logic [ADDR_W_DEF-1:0] reg_idx_t;

    localparam reg_idx_t ZERO_IDX = '0;
endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: index mux, pending lookup and optional
// same-cycle write bypass (REGFILE_BYPASS_EN).
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0] mem,
    input  logic [(1<<ADDR_W)-1:0]             pending,
    input  logic [ADDR_W-1:0]                  rs,
    input  logic [NUM_WR-1:0]                  wen,
    input  logic [NUM_WR*ADDR_W-1:0]           rd,
    input  logic [NUM_WR*DATA_W-1:0]           din,
    output logic [DATA_W-1:0]                  r,
    output logic                               busy
);
    // Register 0 never holds anything but zero when ZERO_REG=1, so no masking is needed here.
    always_comb begin
        r    = mem[rs];
        busy = pending[rs];
`ifdef REGFILE_BYPASS_EN
        // Ascending scan: the highest matching write port is the one shown.
        for (int p = 0; p < NUM_WR; p++) begin
            if (wen[p] && rd[p*ADDR_W +: ADDR_W] == rs && (ZERO_REG == 0 || rs != '0)) begin
                r    = din[p*DATA_W +: DATA_W];
                busy = 1'b0;
            end
        end
`endif
    end

`ifndef REGFILE_BYPASS_EN
    logic unused_bypass;
    assign unused_bypass = ^{wen, rd, din};
`endif
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with pending scoreboard.
// Optional same-cycle write-to-read bypass via REGFILE_BYPASS_EN.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_WR-1:0]        wen,
    input  logic [NUM_WR*ADDR_W-1:0] rd,
    input  logic [NUM_WR*DATA_W-1:0] dIn,
    input  logic [NUM_RD*ADDR_W-1:0] rs,
    output logic [NUM_RD*DATA_W-1:0] r,
    input  logic                     alloc_en,
    input  logic [ADDR_W-1:0]        alloc_rd,
    output logic [NUM_RD-1:0]        rs_busy
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] mem;
    logic [DEPTH-1:0]             pending;

    function automatic logic writable(input logic [ADDR_W-1:0] idx);
        return (ZERO_REG == 0) || (idx != ADDR_W'(ZERO_IDX));
    endfunction

    // Later assignments win: higher write port over lower, alloc over writeback clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem     <= '0;
            pending <= '0;
        end else begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (wen[p] && writable(rd[p*ADDR_W +: ADDR_W])) begin
                    mem[rd[p*ADDR_W +: ADDR_W]]     <= dIn[p*DATA_W +: DATA_W];
                    pending[rd[p*ADDR_W +: ADDR_W]] <= 1'b0;
                end
            end
            if (alloc_en && writable(alloc_rd))
                pending[alloc_rd] <= 1'b1;
        end
    end

    for (genvar q = 0; q < NUM_RD; q++) begin : g_rd
        regfile_rd_port #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .NUM_WR  (NUM_WR),
            .ZERO_REG(ZERO_REG)
        ) u_port (
            .mem    (mem),
            .pending(pending),
            .rs     (rs[q*ADDR_W +: ADDR_W]),
            .wen    (wen),
            .rd     (rd),
            .din    (dIn),
            .r      (r[q*DATA_W +: DATA_W]),
            .busy   (rs_busy[q])
        );
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: array model checked every cycle plus directed literals.
module tb_regfile_mp;
    import regfile_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  wen;
    logic [9:0]  rd;
    logic [63:0] din;
    logic [9:0]  rs;
    logic [63:0] r;
    logic        alloc_en;
    reg_idx_t    alloc_rd;
    logic [1:0]  rs_busy;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    logic [31:0] m_mem [32];
    logic        m_pend[32];

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1)) dut (
        .clk(clk), .rst_n(rst_n), .wen(wen), .rd(rd), .dIn(din), .rs(rs), .r(r),
        .alloc_en(alloc_en), .alloc_rd(alloc_rd), .rs_busy(rs_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference state: written from the architectural rules, register 0 ignored.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                m_mem[i]  = '0;
                m_pend[i] = 1'b0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (wen[p] && rd[p*5 +: 5] != 5'd0) begin
                    m_mem[rd[p*5 +: 5]]  = din[p*32 +: 32];
                    m_pend[rd[p*5 +: 5]] = 1'b0;
                end
            end
            if (alloc_en && alloc_rd != 5'd0) m_pend[alloc_rd] = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int q = 0; q < 2; q++) begin
                logic [4:0]  a;
                logic [31:0] er;
                logic        eb;
                a  = rs[q*5 +: 5];
                er = m_mem[a];
                eb = m_pend[a];
`ifdef REGFILE_BYPASS_EN
                for (int p = 0; p < 2; p++) begin
                    if (wen[p] && rd[p*5 +: 5] == a && a != 5'd0) begin
                        er = din[p*32 +: 32];
                        eb = 1'b0;
                    end
                end
`endif
                check($sformatf("model_r%0d", q), r[q*32 +: 32], er);
                check($sformatf("model_busy%0d", q), {31'd0, rs_busy[q]}, {31'd0, eb});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen      = '0;
        alloc_en = 1'b0;
    endtask

    task automatic wr(input int p, input reg_idx_t a, input logic [31:0] d);
        wen[p]         = 1'b1;
        rd[p*5 +: 5]   = a;
        din[p*32 +: 32] = d;
    endtask

    logic [31:0] exp1;

    initial begin
        rst_n = 1'b0; wen = '0; rd = '0; din = '0; rs = '0; alloc_en = 1'b0; alloc_rd = '0;
        repeat (2) cyc();
        rst_n = 1'b1;
        chk_en = 1'b1;
        cyc();

        // reset: stored value, async clear, write during reset lost
        wr(0, 5'd5, 32'hDEADBEEF); rs[4:0] = 5'd5;
        cyc(); idle(); #1;
        check("pre_reset_x5", r[31:0], 32'hDEADBEEF);
        rst_n = 1'b0; #1;
        check("reset_r", r[31:0], 32'h0);
        check("reset_busy", {31'd0, rs_busy[0]}, 32'h0);
        wr(0, 5'd5, 32'hDEADBEEF);
        cyc(); idle(); rst_n = 1'b1; #1;
        check("reset_midwrite_r", r[31:0], 32'h0);
        cyc();
        check("after_release_r", r[31:0], 32'h0);

        // fill x0..x31 on port 0, then read pairs
        for (int i = 0; i < 32; i++) begin
            idle(); wr(0, reg_idx_t'(i), 32'hFFFFFF00 + 32'(i)); cyc();
        end
        idle();
        for (int i = 1; i < 32; i += 2) begin
            rs[4:0] = reg_idx_t'(i);
            rs[9:5] = reg_idx_t'((i + 1) % 32);
            #1;
            exp1 = (i == 31) ? 32'h0 : 32'hFFFFFF00 + 32'(i + 1);
            check("fill_r0", r[31:0], 32'hFFFFFF00 + 32'(i));
            check("fill_r1", r[63:32], exp1);
            cyc();
        end

        // collision: port 1 wins
        wr(0, 5'd7, 32'h11111111); wr(1, 5'd7, 32'h22222222);
        cyc(); idle(); rs[4:0] = 5'd7; #1;
        check("collision_x7", r[31:0], 32'h22222222);

        // scoreboard
        alloc_en = 1'b1; alloc_rd = 5'd9;
        cyc(); idle(); rs[4:0] = 5'd9; #1;
        check("alloc_busy", {31'd0, rs_busy[0]}, 32'h1);
        cyc();
        wr(0, 5'd9, 32'hA5A5A5A5); #1;
`ifdef REGFILE_BYPASS_EN
        check("wb_busy_same", {31'd0, rs_busy[0]}, 32'h0);
`else
        check("wb_busy_same", {31'd0, rs_busy[0]}, 32'h1);
`endif
        cyc(); idle(); #1;
        check("wb_busy_after", {31'd0, rs_busy[0]}, 32'h0);
        check("wb_data_x9", r[31:0], 32'hA5A5A5A5);

        // alloc and write same register: data lands, stays pending
        alloc_en = 1'b1; alloc_rd = 5'd12; wr(0, 5'd12, 32'hC0C0C0C0); rs[4:0] = 5'd12;
        cyc(); idle(); #1;
        check("alloc_wr_x12", r[31:0], 32'hC0C0C0C0);
        check("alloc_wr_busy", {31'd0, rs_busy[0]}, 32'h1);
        alloc_en = 1'b1; alloc_rd = 5'd0; rs[4:0] = 5'd0;
        cyc(); idle(); #1;
        check("alloc_x0_busy", {31'd0, rs_busy[0]}, 32'h0);

        // bypass visibility
        rs[4:0] = 5'd3; wr(0, 5'd3, 32'h12345678); #1;
`ifdef REGFILE_BYPASS_EN
        check("bypass_same", r[31:0], 32'h12345678);
`else
        check("bypass_same", r[31:0], 32'hFFFFFF03);
`endif
        cyc(); idle(); #1;
        check("bypass_after", r[31:0], 32'h12345678);

        // random traffic, checked by the model every cycle
        for (int k = 0; k < 60; k++) begin
            wen      = 2'($urandom);
            rd       = 10'($urandom);
            din      = {$urandom, $urandom};
            rs       = 10'($urandom);
            alloc_en = 1'($urandom);
            alloc_rd = 5'($urandom);
            cyc();
        end
        idle();
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
